// File: rtl/song_player_ctrl_if.sv
// Song ROM bus: the player drives address/song select, the ROM answers
// combinationally with the note and its duration.
interface song_player_ctrl_if #(
    parameter int ADDR_W = 9,
    parameter int DUR_W  = 32
);
    logic [ADDR_W-1:0] rom_address;
    logic [3:0]        rom_song;
    logic [3:0]        rom_note;
    logic [DUR_W-1:0]  rom_duration;

    modport master (
        output rom_address,
        output rom_song,
        input  rom_note,
        input  rom_duration
    );

    modport slave (
        input  rom_address,
        input  rom_song,
        output rom_note,
        output rom_duration
    );
endinterface

// File: rtl/song_player_ctrl.sv
// Song sequencer: steps the song ROM, times each note from its duration
// field, inserts a silent gap between notes, and handles pause/stop/loop.
module song_player_ctrl #(
    parameter int ADDR_W     = 9,
    parameter int DUR_W      = 32,
    parameter int GAP_CYCLES = 100_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    song_player_ctrl_if.master    rom,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  pause,
    input  logic                  loop_en,
    input  logic [3:0]            song_sel,
    output logic [3:0]            note_out,
    output logic                  note_valid,
    output logic                  playing,
    output logic                  done
);

    localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD =
        GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        PLAY,
        GAP,
        DONE
    } state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [3:0]        song_reg;
    logic [3:0]        note_reg;
    logic [DUR_W-1:0]  dur_cnt_reg;
    logic [GAP_W-1:0]  gap_cnt_reg;
    logic              done_reg;

    // Where "advance to the next note" lands; shared by PLAY (no gap) and GAP.
    logic [ADDR_W-1:0] adv_addr_next;
    state_t            adv_state_next;

    always_comb begin
        adv_addr_next  = addr_reg;
        adv_state_next = FETCH;
        if (addr_reg != {ADDR_W{1'b1}}) begin
            adv_addr_next = addr_reg + ADDR_W'(1);
        end else if (loop_en) begin
            adv_addr_next = '0;
        end else begin
            adv_state_next = DONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            addr_reg    <= '0;
            song_reg    <= '0;
            note_reg    <= '0;
            dur_cnt_reg <= '0;
            gap_cnt_reg <= '0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (stop) begin
                state_reg <= IDLE;
                note_reg  <= '0;
                addr_reg  <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start) begin
                            song_reg  <= song_sel;
                            addr_reg  <= '0;
                            state_reg <= FETCH;
                        end
                    end
                    FETCH: begin
                        // ROM outputs have settled for the current address by now.
                        if (rom.rom_duration != '0) begin
                            note_reg    <= rom.rom_note;
                            dur_cnt_reg <= rom.rom_duration - DUR_W'(1);
                            state_reg   <= PLAY;
                        end else if ((addr_reg != '0) && loop_en) begin
                            addr_reg <= '0;
                        end else begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end
                    end
                    PLAY: begin
                        if (!pause) begin
                            if (dur_cnt_reg != '0) begin
                                dur_cnt_reg <= dur_cnt_reg - DUR_W'(1);
                            end else begin
                                note_reg <= '0;
                                if (GAP_CYCLES > 0) begin
                                    gap_cnt_reg <= GAP_LOAD;
                                    state_reg   <= GAP;
                                end else begin
                                    addr_reg  <= adv_addr_next;
                                    state_reg <= adv_state_next;
                                    done_reg  <= (adv_state_next == DONE);
                                end
                            end
                        end
                    end
                    GAP: begin
                        if (!pause) begin
                            if (gap_cnt_reg != '0) begin
                                gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
                            end else begin
                                addr_reg  <= adv_addr_next;
                                state_reg <= adv_state_next;
                                done_reg  <= (adv_state_next == DONE);
                            end
                        end
                    end
                    DONE: begin
                        addr_reg  <= '0;
                        state_reg <= IDLE;
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign rom.rom_address = addr_reg;
    assign rom.rom_song    = song_reg;

    // Pause mutes the output without disturbing the held note.
    assign note_out   = ((state_reg == PLAY) && !pause) ? note_reg : 4'd0;
    assign note_valid = (note_out != 4'd0);
    assign playing    = (state_reg == FETCH) || (state_reg == PLAY) || (state_reg == GAP);
    assign done       = done_reg;

endmodule

// File: tb/tb_song_player_ctrl.sv
// Directed bench for song_player_ctrl with a small stub song ROM.
module tb_song_player_ctrl;

    localparam int ADDR_W     = 3;
    localparam int DUR_W      = 16;
    localparam int GAP_CYCLES = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, stop, pause, loop_en;
    logic [3:0] song_sel;
    logic [3:0] note_out;
    logic       note_valid, playing, done;

    int checks_total  = 0;
    int checks_passed = 0;

    song_player_ctrl_if #(.ADDR_W(ADDR_W), .DUR_W(DUR_W)) rom_if ();

    song_player_ctrl #(
        .ADDR_W(ADDR_W),
        .DUR_W(DUR_W),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rom(rom_if),
        .start(start),
        .stop(stop),
        .pause(pause),
        .loop_en(loop_en),
        .song_sel(song_sel),
        .note_out(note_out),
        .note_valid(note_valid),
        .playing(playing),
        .done(done)
    );

    always #5 clk = ~clk;

    // Song 0: {1,3},{5,2},end. Song 1: empty. Song 2: {7,10},end. Song 3: eight {2,1}, no terminator.
    always_comb begin
        rom_if.rom_note     = 4'd0;
        rom_if.rom_duration = '0;
        case (rom_if.rom_song)
            4'd0: begin
                if (rom_if.rom_address == 3'd0) begin
                    rom_if.rom_note = 4'd1; rom_if.rom_duration = 16'd3;
                end else if (rom_if.rom_address == 3'd1) begin
                    rom_if.rom_note = 4'd5; rom_if.rom_duration = 16'd2;
                end
            end
            4'd2: begin
                if (rom_if.rom_address == 3'd0) begin
                    rom_if.rom_note = 4'd7; rom_if.rom_duration = 16'd10;
                end
            end
            4'd3: begin
                rom_if.rom_note = 4'd2; rom_if.rom_duration = 16'd1;
            end
            default: ;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0; song_sel = 4'd0;
        tick(); tick();
        checks_total++;
        if ({note_out, note_valid, playing, done} !== 7'd0)
            $display("FAIL reset_outputs got=%b exp=0", {note_out, note_valid, playing, done});
        else checks_passed++;
        checks_total++;
        if ({rom_if.rom_address, rom_if.rom_song} !== 7'd0)
            $display("FAIL reset_rom_bus got=%b exp=0", {rom_if.rom_address, rom_if.rom_song});
        else checks_passed++;
        @(negedge clk); rst_n = 1'b1;
        tick();
        $display("test_reset complete");
    endtask

    task automatic test_basic();
        logic [3:0] exp_note [14] = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0,
                                      4'd5, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        song_sel = 4'd0; loop_en = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; song_sel = 4'd3;
        for (int k = 0; k < 14; k++) begin
            if (k > 0) tick();
            checks_total++;
            if (note_out !== exp_note[k])
                $display("FAIL basic_note k=%0d got=%0d exp=%0d", k, note_out, exp_note[k]);
            else checks_passed++;
            checks_total++;
            if (note_valid !== (exp_note[k] != 4'd0))
                $display("FAIL basic_valid k=%0d got=%0b exp=%0b", k, note_valid, exp_note[k] != 4'd0);
            else checks_passed++;
            checks_total++;
            if (done !== (k == 12))
                $display("FAIL basic_done k=%0d got=%0b exp=%0b", k, done, k == 12);
            else checks_passed++;
            checks_total++;
            if (playing !== (k < 12))
                $display("FAIL basic_playing k=%0d got=%0b exp=%0b", k, playing, k < 12);
            else checks_passed++;
        end
        checks_total++;
        if (rom_if.rom_song !== 4'd0)
            $display("FAIL basic_song_latched got=%0d exp=0", rom_if.rom_song);
        else checks_passed++;
        checks_total++;
        if (rom_if.rom_address !== 3'd0)
            $display("FAIL basic_addr_idle got=%0d exp=0", rom_if.rom_address);
        else checks_passed++;
        $display("test_basic complete");
    endtask

    task automatic test_loop();
        int done_seen = 0;
        song_sel = 4'd0; loop_en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (done) done_seen++;
            if (k == 12) begin
                checks_total++;
                if ({rom_if.rom_address, playing, note_out} !== {3'd0, 1'b1, 4'd0})
                    $display("FAIL loop_refetch got addr=%0d playing=%0b note=%0d exp addr=0 playing=1 note=0",
                             rom_if.rom_address, playing, note_out);
                else checks_passed++;
            end
            if (k == 13) begin
                checks_total++;
                if (note_out !== 4'd1)
                    $display("FAIL loop_replay got=%0d exp=1", note_out);
                else checks_passed++;
            end
        end
        checks_total++;
        if (done_seen !== 0)
            $display("FAIL loop_no_done got=%0d exp=0", done_seen);
        else checks_passed++;
        stop = 1'b1; tick(); stop = 1'b0; loop_en = 1'b0;
        checks_total++;
        if (playing !== 1'b0)
            $display("FAIL loop_stop got=%0b exp=0", playing);
        else checks_passed++;
        $display("test_loop complete");
    endtask

    task automatic test_pause();
        int audible = 0;
        int paused_audible = 0;
        int done_seen = 0;
        song_sel = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            pause = (c >= 3) && (c < 8);
            #1;
            if (note_valid) audible++;
            if (pause && (note_valid || note_out != 4'd0)) paused_audible++;
            if (done) done_seen++;
            if (c == 8) begin
                checks_total++;
                if (note_out !== 4'd7)
                    $display("FAIL pause_resume_note got=%0d exp=7", note_out);
                else checks_passed++;
            end
            tick();
        end
        pause = 1'b0;
        checks_total++;
        if (audible !== 10)
            $display("FAIL pause_audible_cycles got=%0d exp=10", audible);
        else checks_passed++;
        checks_total++;
        if (paused_audible !== 0)
            $display("FAIL pause_mute got=%0d exp=0", paused_audible);
        else checks_passed++;
        checks_total++;
        if (done_seen !== 1)
            $display("FAIL pause_done_count got=%0d exp=1", done_seen);
        else checks_passed++;
        $display("test_pause complete");
    endtask

    task automatic test_stop();
        int done_seen = 0;
        song_sel = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        checks_total++;
        if ({playing, note_out} !== {1'b1, 4'd0})
            $display("FAIL stop_in_gap_pre got playing=%0b note=%0d exp playing=1 note=0", playing, note_out);
        else checks_passed++;
        stop = 1'b1; tick(); stop = 1'b0;
        checks_total++;
        if ({playing, note_out, done, rom_if.rom_address} !== {1'b0, 4'd0, 1'b0, 3'd0})
            $display("FAIL stop_in_gap got playing=%0b note=%0d done=%0b addr=%0d exp all 0",
                     playing, note_out, done, rom_if.rom_address);
        else checks_passed++;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (done || playing) done_seen++;
        end
        checks_total++;
        if (done_seen !== 0)
            $display("FAIL stop_stays_idle got=%0d exp=0", done_seen);
        else checks_passed++;
        song_sel = 4'd2; start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        checks_total++;
        if (playing !== 1'b0)
            $display("FAIL stop_beats_start got=%0b exp=0", playing);
        else checks_passed++;
        checks_total++;
        if (rom_if.rom_song !== 4'd0)
            $display("FAIL stop_start_no_latch got=%0d exp=0", rom_if.rom_song);
        else checks_passed++;
        tick();
        checks_total++;
        if (playing !== 1'b0)
            $display("FAIL stop_start_after got=%0b exp=0", playing);
        else checks_passed++;
        $display("test_stop complete");
    endtask

    task automatic test_empty_song();
        song_sel = 4'd1; loop_en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        checks_total++;
        if ({playing, done} !== 2'b10)
            $display("FAIL empty_fetch got=%b exp=10", {playing, done});
        else checks_passed++;
        tick();
        checks_total++;
        if ({playing, done} !== 2'b01)
            $display("FAIL empty_done got=%b exp=01", {playing, done});
        else checks_passed++;
        tick();
        checks_total++;
        if ({playing, done} !== 2'b00)
            $display("FAIL empty_idle got=%b exp=00", {playing, done});
        else checks_passed++;
        loop_en = 1'b0; song_sel = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        checks_total++;
        if (playing !== 1'b1)
            $display("FAIL empty_restart got=%0b exp=1", playing);
        else checks_passed++;
        stop = 1'b1; tick(); stop = 1'b0;
        $display("test_empty_song complete");
    endtask

    task automatic test_async_reset();
        song_sel = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 7; k++) tick();
        checks_total++;
        if (note_out !== 4'd5)
            $display("FAIL areset_pre_note got=%0d exp=5", note_out);
        else checks_passed++;
        #2 rst_n = 1'b0;
        #1;
        checks_total++;
        if ({note_out, note_valid, playing, rom_if.rom_address} !== 9'd0)
            $display("FAIL areset_immediate got note=%0d valid=%0b playing=%0b addr=%0d exp all 0",
                     note_out, note_valid, playing, rom_if.rom_address);
        else checks_passed++;
        @(negedge clk); rst_n = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks_total++;
        if ({playing, rom_if.rom_address} !== {1'b1, 3'd0})
            $display("FAIL areset_restart got playing=%0b addr=%0d exp playing=1 addr=0",
                     playing, rom_if.rom_address);
        else checks_passed++;
        tick();
        checks_total++;
        if (note_out !== 4'd1)
            $display("FAIL areset_first_note got=%0d exp=1", note_out);
        else checks_passed++;
        stop = 1'b1; tick(); stop = 1'b0;
        $display("test_async_reset complete");
    endtask

    task automatic test_addr_end();
        int audible = 0;
        song_sel = 4'd3; loop_en = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            tick();
            if (note_valid) audible++;
            if (k == 28) begin
                checks_total++;
                if ({rom_if.rom_address, playing} !== {3'd7, 1'b1})
                    $display("FAIL addr_end_last got addr=%0d playing=%0b exp addr=7 playing=1",
                             rom_if.rom_address, playing);
                else checks_passed++;
            end
            if (k == 32) begin
                checks_total++;
                if ({done, playing} !== 2'b10)
                    $display("FAIL addr_end_done got=%b exp=10", {done, playing});
                else checks_passed++;
            end
        end
        checks_total++;
        if ({playing, rom_if.rom_address} !== {1'b0, 3'd0})
            $display("FAIL addr_end_idle got playing=%0b addr=%0d exp playing=0 addr=0",
                     playing, rom_if.rom_address);
        else checks_passed++;
        checks_total++;
        if (audible !== 8)
            $display("FAIL addr_end_notes got=%0d exp=8", audible);
        else checks_passed++;
        $display("test_addr_end complete");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_loop();
        test_pause();
        test_stop();
        test_empty_song();
        test_async_reset();
        test_addr_end();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/song_player_ctrl.md
Name: song_player_ctrl

Overview:
Sequencer that plays one stored song by stepping the song ROM address and timing each note from the ROM duration field. It latches the song selection on start, feeds one note at a time to the tone generator/buzzer driver, inserts a fixed silent gap between notes, and supports pause, stop and optional looping. It sits between the keyboard mode/UI logic and the combinational song ROM. It is the only master of the ROM address and song-select inputs.

Parameters:
ADDR_W, 9, ROM address width; the last address is 2^ADDR_W-1.
DUR_W, 32, width of the ROM note_duration field and of the internal duration counter.
GAP_CYCLES, 100_000, silent clock cycles inserted after every note; 0 means no gap state.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle request to begin playback of song_sel.
stop  in  1  abort playback; level or pulse.
pause  in  1  level; freezes playback while high.
loop_en  in  1  sampled at end of song; 1 means restart from address 0.
song_sel  in  4  song index; latched on accepted start.
rom_address  out  ADDR_W  address to song ROM.
rom_song  out  4  selected_song to song ROM.
rom_note  in  4  note from ROM (0 = rest).
rom_duration  in  DUR_W  note duration in cycles from ROM (0 = end of song).
note_out  out  4  note to tone generator; 0 = silence.
note_valid  out  1  high while an audible note is sounding.
playing  out  1  high in any state except IDLE/DONE.
done  out  1  one-cycle pulse on natural end of song without loop.

Behaviour:
- Reset (async, rst_n=0): state IDLE; rom_address=0, rom_song=0, note_reg=0, dur_cnt=0, gap_cnt=0, done=0. Therefore note_out=0, note_valid=0, playing=0.
- The ROM is combinational. Its outputs are valid in the cycle after rom_address/rom_song change. The controller always spends one FETCH cycle before sampling them.
- States: IDLE, FETCH, PLAY, GAP, DONE.
- IDLE:
  - start=1 and stop=0: latch rom_song<=song_sel, rom_address<=0, go to FETCH.
  - Otherwise stay in IDLE.
- FETCH: sample rom_duration and rom_note.
  - rom_duration!=0: note_reg<=rom_note, dur_cnt<=rom_duration-1, go to PLAY.
  - rom_duration==0 and rom_address!=0 and loop_en=1: rom_address<=0, stay in FETCH.
  - rom_duration==0 in any other case (including an empty song at address 0): go to DONE.
  - pause is ignored in FETCH.
- PLAY:
  - pause=1: hold all counters.
  - pause=0 and dur_cnt!=0: dur_cnt decrements.
  - pause=0 and dur_cnt==0: note_reg<=0. Then:
    - GAP_CYCLES>0: gap_cnt<=GAP_CYCLES-1, go to GAP.
    - GAP_CYCLES==0: advance.
  - A note of duration D occupies exactly D unpaused PLAY cycles.
- GAP:
  - pause=1: hold.
  - gap_cnt!=0: gap_cnt decrements.
  - gap_cnt==0: advance.
- Advance:
  - rom_address != 2^ADDR_W-1: rom_address<=rom_address+1, go to FETCH.
  - rom_address == 2^ADDR_W-1: treat as end of song. If loop_en=1, rom_address<=0 and go to FETCH; otherwise go to DONE. The address never wraps silently.
- DONE: done=1 for exactly this cycle; rom_address<=0; go to IDLE.
- Per-note period: 1 (FETCH) + D + GAP_CYCLES cycles.
- Outputs:
  - note_out = note_reg when state==PLAY and pause==0, else 0. This is a combinational mute on pause; note_reg itself is retained.
  - note_valid = (note_out!=0).
  - playing = state in {FETCH, PLAY, GAP}.
- stop=1: from any state, go to IDLE on the next edge; note_reg<=0, rom_address<=0, no done pulse. stop has priority over start, pause and all advancing.
- start while playing=1 is ignored. A new song requires stop, or reaching IDLE first.
- song_sel changes during playback have no effect; only the value latched at start is used.
- Reset asserted mid-note: all outputs return to reset values immediately, without waiting for a clock edge.
- Counter arithmetic is unsigned DUR_W-bit. The decrement from 0 never occurs, because the state exits on 0.

Test Plan:
1. Stub ROM song 0 = {note 1 dur 3, note 5 dur 2, dur 0}, GAP_CYCLES=2, pulse start -> note_out: 0 (FETCH), 1,1,1, 0,0 (gap), 0 (FETCH), 5,5, 0,0, 0 (FETCH); then done pulses once; playing=0 after.
2. Same song with loop_en=1 -> after the address-2 FETCH sees dur 0, rom_address returns to 0 and note 1 replays; done never pulses.
3. Pause high for 5 cycles mid-way through note 1 of a dur-10 note -> note_out=0 and note_valid=0 during pause; the note then completes its remaining cycles, giving exactly 10 audible cycles in total.
4. Stop asserted during GAP, and in the same cycle as start from IDLE -> IDLE next cycle, note_out=0, no done pulse; start is not accepted.
5. Empty song (dur 0 at address 0) with loop_en=1 -> FETCH, DONE, IDLE; done pulses once; no lock-up.
6. Async reset asserted while note 5 is sounding -> note_out=0, playing=0, rom_address=0 before the next clk edge; a new start replays from address 0.
